pdl_dll_ctrl: RTL and testbench

Delay-calibration controller for the AIB RXCLK programmable delay line. Consumes samples from an early/late phase detector comparing delayed against reference clock, filters them, and steps a saturating 0..64 delay code. Drives the delay line's 64-bit thermometer control bus `bk[63:0]` directly, one cell per step, and flags lock once the loop dithers around the target phase.

---
 rtl/pdl_dll_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_pdl_dll_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pdl_dll_ctrl.sv
// ---------------------------------------------------------------------------
// pdl_dll_ctrl
// Delay-calibration controller for the AIB RXCLK programmable delay line.
// Majority-votes FILT_LEN early/late phase-detector samples, then moves a
// saturating 0..64 delay code one step per vote. The code is driven to the
// line as a 64-bit thermometer. Lock is declared after LOCK_REV direction
// reversals, which means the loop is dithering around the target phase.
//
// Optional feature macro: PDL_DLL_TRACK_EN
//   defined     : LOCKED keeps looping (settle/sample/update) to track drift;
//                 a saturation event while tracking drops lock and restarts
//                 reversal counting.
//   not defined : LOCKED freezes the code until en drops, override or reset.
//
// Ports
//   clk       in   controller clock, rising edge
//   reset     in   synchronous, active-high
//   en        in   calibration enable (level)
//   pd_valid  in   pd_early qualifier
//   pd_early  in   1 = delayed clock early (add delay), 0 = late
//   ovr_en    in   manual code override, highest priority after reset
//   ovr_code  in   override code, values above 64 clamp to 64
//   bk        out  thermometer control, bk[i] = (i < code)
//   code      out  current binary delay code
//   busy      out  FSM not idle
//   locked    out  lock achieved
//   sat       out  last nonzero vote tried to push past 0 or 64
// ---------------------------------------------------------------------------
module pdl_dll_ctrl #(
    parameter int START_CODE = 32,
    parameter int SETTLE_CYC = 4,
    parameter int FILT_LEN   = 8,
    parameter int LOCK_REV   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        pd_valid,
    input  logic        pd_early,
    input  logic        ovr_en,
    input  logic [6:0]  ovr_code,
    output logic [63:0] bk,
    output logic [6:0]  code,
    output logic        busy,
    output logic        locked,
    output logic        sat
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    localparam logic [6:0] CODE_MAX    = 7'd64;
    localparam logic [6:0] START_C     = 7'(START_CODE);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] FILT_LAST   = 8'(FILT_LEN - 1);
    localparam logic [3:0] LOCK_N      = 4'(LOCK_REV);

    // Thermometer encode: cell i enabled iff i < c; 64 gives all ones.
    function automatic logic [63:0] therm(input logic [6:0] c);
        logic [63:0] t;
        t = 64'd0;
        for (int i = 0; i < 64; i++) begin
            t[i] = (7'(i) < c);
        end
        return t;
    endfunction

    state_t             state_r, state_s;
    logic [7:0]         settle_cnt_r, settle_cnt_s;
    logic [7:0]         samp_cnt_r, samp_cnt_s;
    logic signed [8:0]  vote_r, vote_s;
    logic [3:0]         rev_cnt_r, rev_cnt_s;
    logic               last_up_r, last_up_s;
    logic               dir_vld_r, dir_vld_s;
    logic [6:0]         code_s;
    logic               locked_s;
    logic               sat_s;
    logic               step_up_s;
    logic               sat_hit_s;

    // Next-state, counters, vote and code computation.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        samp_cnt_s   = samp_cnt_r;
        vote_s       = vote_r;
        rev_cnt_s    = rev_cnt_r;
        last_up_s    = last_up_r;
        dir_vld_s    = dir_vld_r;
        code_s       = code;
        locked_s     = locked;
        sat_s        = sat;
        step_up_s    = 1'b0;
        sat_hit_s    = 1'b0;

        if (ovr_en) begin
            code_s       = (ovr_code > CODE_MAX) ? CODE_MAX : ovr_code;
            state_s      = ST_IDLE;
            settle_cnt_s = 8'd0;
            samp_cnt_s   = 8'd0;
            vote_s       = 9'sd0;
            rev_cnt_s    = 4'd0;
            dir_vld_s    = 1'b0;
            locked_s     = 1'b0;
            sat_s        = 1'b0;
        end else if (!en) begin
            // Abort: keep the code, drop lock and any partial vote.
            state_s      = ST_IDLE;
            settle_cnt_s = 8'd0;
            samp_cnt_s   = 8'd0;
            vote_s       = 9'sd0;
            locked_s     = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    code_s       = START_C;
                    rev_cnt_s    = 4'd0;
                    dir_vld_s    = 1'b0;
                    settle_cnt_s = 8'd0;
                    samp_cnt_s   = 8'd0;
                    vote_s       = 9'sd0;
                    state_s      = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_r >= SETTLE_LAST) begin
                        settle_cnt_s = 8'd0;
                        state_s      = ST_SAMPLE;
                    end else begin
                        settle_cnt_s = settle_cnt_r + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (pd_valid) begin
                        vote_s = pd_early ? (vote_r + 9'sd1) : (vote_r - 9'sd1);
                        if (samp_cnt_r >= FILT_LAST) begin
                            samp_cnt_s = 8'd0;
                            state_s    = ST_UPDATE;
                        end else begin
                            samp_cnt_s = samp_cnt_r + 8'd1;
                        end
                    end else begin
                        vote_s = vote_r;
                    end
                end
                ST_UPDATE: begin
                    vote_s = 9'sd0;
                    if (vote_r != 9'sd0) begin
                        step_up_s = (vote_r > 9'sd0);
                        if (step_up_s) begin
                            if (code >= CODE_MAX) begin
                                sat_hit_s = 1'b1;
                            end else begin
                                code_s = code + 7'd1;
                            end
                        end else begin
                            if (code == 7'd0) begin
                                sat_hit_s = 1'b1;
                            end else begin
                                code_s = code - 7'd1;
                            end
                        end
                        sat_s = sat_hit_s;
                        // A step against the previous direction is a reversal.
                        if (dir_vld_r && (last_up_r != step_up_s)) begin
                            rev_cnt_s = (rev_cnt_r == 4'd15) ? 4'd15 : (rev_cnt_r + 4'd1);
                        end else begin
                            rev_cnt_s = rev_cnt_r;
                        end
                        last_up_s = step_up_s;
                        dir_vld_s = 1'b1;
                    end else begin
                        // Balanced vote: no step and no direction recorded.
                        sat_s = sat;
                    end
`ifdef PDL_DLL_TRACK_EN
                    if (locked) begin
                        if (sat_hit_s) begin
                            locked_s  = 1'b0;
                            rev_cnt_s = 4'd0;
                            dir_vld_s = 1'b0;
                            state_s   = ST_SETTLE;
                        end else begin
                            state_s = ST_LOCKED;
                        end
                    end else if (rev_cnt_s >= LOCK_N) begin
                        locked_s = 1'b1;
                        state_s  = ST_LOCKED;
                    end else begin
                        state_s = ST_SETTLE;
                    end
`else
                    if (rev_cnt_s >= LOCK_N) begin
                        locked_s = 1'b1;
                        state_s  = ST_LOCKED;
                    end else begin
                        state_s = ST_SETTLE;
                    end
`endif
                end
                ST_LOCKED: begin
`ifdef PDL_DLL_TRACK_EN
                    // Tracking: LOCKED acts as the settle phase of the loop.
                    if (settle_cnt_r >= SETTLE_LAST) begin
                        settle_cnt_s = 8'd0;
                        state_s      = ST_SAMPLE;
                    end else begin
                        settle_cnt_s = settle_cnt_r + 8'd1;
                    end
`else
                    // Frozen: code and lock held, phase detector ignored.
                    state_s = ST_LOCKED;
`endif
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs; bk follows next-code directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= 8'd0;
            samp_cnt_r   <= 8'd0;
            vote_r       <= 9'sd0;
            rev_cnt_r    <= 4'd0;
            last_up_r    <= 1'b0;
            dir_vld_r    <= 1'b0;
            code         <= START_C;
            bk           <= therm(START_C);
            busy         <= 1'b0;
            locked       <= 1'b0;
            sat          <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            samp_cnt_r   <= samp_cnt_s;
            vote_r       <= vote_s;
            rev_cnt_r    <= rev_cnt_s;
            last_up_r    <= last_up_s;
            dir_vld_r    <= dir_vld_s;
            code         <= code_s;
            bk           <= therm(code_s);
            busy         <= (state_s != ST_IDLE);
            locked       <= locked_s;
            sat          <= sat_s;
        end
    end

endmodule

// File: tb/tb_pdl_dll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pdl_dll_ctrl
// Scoreboard bench for pdl_dll_ctrl (default build, tracking disabled).
// Stimulus pushes the hand-computed output tuple and the cycle at which it
// must appear; the monitor pops one entry every time any output changes.
// ---------------------------------------------------------------------------
module tb_pdl_dll_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        pd_valid;
    logic        pd_early;
    logic        ovr_en;
    logic [6:0]  ovr_code;
    logic [63:0] bk;
    logic [6:0]  code;
    logic        busy;
    logic        locked;
    logic        sat;

    pdl_dll_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .pd_valid (pd_valid),
        .pd_early (pd_early),
        .ovr_en   (ovr_en),
        .ovr_code (ovr_code),
        .bk       (bk),
        .code     (code),
        .busy     (busy),
        .locked   (locked),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] code;
        logic       busy;
        logic       locked;
        logic       sat;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;
    bit   first_obs = 1'b1;
    logic [73:0] prev_obs;

    // phase-detector plant: 0 = always early, 1 = early iff code <= target,
    // 2 = valid every 3rd cycle with alternating early/late
    int   pd_mode = 0;
    int   pd_target = 40;
    logic pd_tog = 1'b0;

    function automatic logic [63:0] ref_therm(input logic [6:0] c);
        logic [63:0] t;
        for (int i = 0; i < 64; i++) t[i] = (i < int'(c));
        return t;
    endfunction

    task automatic push(input logic [6:0] c, input logic b, input logic l,
                        input logic s, input int at);
        exp_t e;
        e.code = c; e.busy = b; e.locked = l; e.sat = s; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (pd_mode)
                0: begin pd_valid = 1'b1; pd_early = 1'b1; end
                1: begin pd_valid = 1'b1; pd_early = (int'(code) <= pd_target); end
                default: begin
                    pd_valid = ((cyc % 3) == 0);
                    if (pd_valid) begin
                        pd_early = pd_tog;
                        pd_tog   = ~pd_tog;
                    end
                end
            endcase
        end
    endtask

    // Monitor: any output change must match the next scoreboard entry.
    always @(posedge clk) begin
        logic [73:0] obs;
        exp_t e;
        bit ok;
        #1;
        if (mon_on) begin
            obs = {bk, code, busy, locked, sat};
            if (first_obs || (obs !== prev_obs)) begin
                first_obs = 1'b0;
                prev_obs  = obs;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got code=%0d busy=%b locked=%b sat=%b at cycle %0d, required no change",
                             code, busy, locked, sat, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (code === e.code) && (bk === ref_therm(e.code)) &&
                         (busy === e.busy) && (locked === e.locked) &&
                         (sat === e.sat) && ((e.cyc < 0) || (cyc == e.cyc));
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL output_event: got code=%0d bk=%h busy=%b locked=%b sat=%b cyc=%0d, required code=%0d bk=%h busy=%b locked=%b sat=%b cyc=%0d",
                                 code, bk, busy, locked, sat, cyc,
                                 e.code, ref_therm(e.code), e.busy, e.locked, e.sat, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        exp_t e;
        reset = 1'b1; en = 1'b0; pd_valid = 1'b0; pd_early = 1'b0;
        ovr_en = 1'b0; ovr_code = 7'd0;
        step(3);

        // reset state: code 32, lower 32 cells on, idle
        reset = 1'b0;
        push(7'd32, 1'b0, 1'b0, 1'b0, -1);
        mon_on = 1'b1;
        step(4);

        // constant early: first step 14 cycles after en, then every 13, sat at 64
        pd_mode = 0;
        en = 1'b1; t0 = cyc;
        push(7'd32, 1'b1, 1'b0, 1'b0, t0 + 1);
        for (int c = 33; c <= 64; c++)
            push(7'(c), 1'b1, 1'b0, 1'b0, t0 + 14 + 13 * (c - 33));
        push(7'd64, 1'b1, 1'b0, 1'b1, t0 + 14 + 13 * 32);
        step(440);
        en = 1'b0; t0 = cyc;
        push(7'd64, 1'b0, 1'b0, 1'b1, t0 + 1);
        step(3);

        // override: clamp 0 / 100 / 50, sat cleared
        ovr_en = 1'b1; ovr_code = 7'd0; t0 = cyc;
        push(7'd0, 1'b0, 1'b0, 1'b0, t0 + 1);
        step(2);
        ovr_code = 7'd100; t0 = cyc;
        push(7'd64, 1'b0, 1'b0, 1'b0, t0 + 1);
        step(2);
        ovr_code = 7'd50; t0 = cyc;
        push(7'd50, 1'b0, 1'b0, 1'b0, t0 + 1);
        step(2);
        ovr_en = 1'b0;
        step(3);

        // dither 40/41: lock on 2nd reversal, then frozen despite PD change
        pd_mode = 1; pd_target = 40;
        en = 1'b1; t0 = cyc;
        push(7'd32, 1'b1, 1'b0, 1'b0, t0 + 1);
        for (int c = 33; c <= 41; c++)
            push(7'(c), 1'b1, 1'b0, 1'b0, t0 + 14 + 13 * (c - 33));
        push(7'd40, 1'b1, 1'b0, 1'b0, t0 + 131);
        push(7'd41, 1'b1, 1'b1, 1'b0, t0 + 144);
        step(150);
        pd_target = 30;
        step(60);
        en = 1'b0; t0 = cyc;
        push(7'd41, 1'b0, 1'b0, 1'b0, t0 + 1);
        step(3);

        // override mid-SAMPLE with en still high
        pd_target = 40;
        en = 1'b1; t0 = cyc;
        push(7'd32, 1'b1, 1'b0, 1'b0, t0 + 1);
        step(8);
        ovr_en = 1'b1; ovr_code = 7'd100; t0 = cyc;
        push(7'd64, 1'b0, 1'b0, 1'b0, t0 + 1);
        step(2);
        ovr_code = 7'd0; t0 = cyc;
        push(7'd0, 1'b0, 1'b0, 1'b0, t0 + 1);
        step(2);

        // release restarts at 32; balanced sparse votes never step
        pd_mode = 2;
        ovr_en = 1'b0; t0 = cyc;
        push(7'd32, 1'b1, 1'b0, 1'b0, t0 + 1);
        step(60);
        en = 1'b0; t0 = cyc;
        push(7'd32, 1'b0, 1'b0, 1'b0, t0 + 1);
        step(2);

        // en dropped mid-SETTLE
        en = 1'b1; t0 = cyc;
        push(7'd32, 1'b1, 1'b0, 1'b0, t0 + 1);
        step(3);
        en = 1'b0; t0 = cyc;
        push(7'd32, 1'b0, 1'b0, 1'b0, t0 + 1);
        step(5);

        mon_on = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: got no change, required code=%0d busy=%b locked=%b sat=%b at cycle %0d",
                     e.code, e.busy, e.locked, e.sat, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
